// File: rtl/pingpong_symbol_reader.sv
// Read side of the two-bank modulation symbol buffer: drains the bank the mapper just closed
// into a valid/ready stream. Optional frame/drop counters are enabled with PPR_FRAME_CNT_EN.
module pingpong_symbol_reader #(
  parameter int LUT_WIDTH  = 18,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 1200
) (
  input  logic                        CLK_PPR,
  input  logic                        RST_PPR,
  input  logic                        PINGPONG_SWITCH,
  input  logic [ADDR_WIDTH-1:0]       Last_addr,
  output logic                        Wr_Bank,
  output logic                        Rd_Bank,
  output logic [ADDR_WIDTH-1:0]       Rd_addr,
  output logic                        read_enable,
  input  logic signed [LUT_WIDTH-1:0] Ram_I,
  input  logic signed [LUT_WIDTH-1:0] Ram_Q,
  output logic signed [LUT_WIDTH-1:0] Out_I,
  output logic signed [LUT_WIDTH-1:0] Out_Q,
  output logic                        Out_Valid,
  input  logic                        Out_Ready,
  output logic                        Out_Last,
  output logic                        Rd_Done,
  output logic                        Overflow
`ifdef PPR_FRAME_CNT_EN
  ,
  output logic [15:0]                 Frame_Cnt,
  output logic [7:0]                  Drop_Cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    act_bank_q, act_bank_d;
  logic [ADDR_WIDTH-1:0]   act_len_q, act_len_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    pend_valid_q, pend_valid_d;
  logic                    pend_bank_q, pend_bank_d;
  logic [ADDR_WIDTH-1:0]   pend_len_q, pend_len_d;
  logic                    inflight_q, inflight_d;
  logic                    inflight_last_q, inflight_last_d;
  logic [1:0]              fifo_count_q, fifo_count_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    overflow_q, overflow_d;

  logic signed [LUT_WIDTH-1:0] fifo_i_q [2];
  logic signed [LUT_WIDTH-1:0] fifo_qd_q [2];
  logic                        fifo_last_q [2];

  logic                  sw_valid, done_now, active_free, accept, drop;
  logic                  out_valid, pop, push, issue, at_last;
  logic [ADDR_WIDTH-1:0] sw_len;
  logic [2:0]            occ;

  assign sw_valid    = PINGPONG_SWITCH && (Last_addr != '0);
  assign sw_len      = (Last_addr > MAX_LEN) ? MAX_LEN : Last_addr;
  assign out_valid   = (fifo_count_q != 2'd0);
  assign pop         = out_valid && Out_Ready;
  assign push        = inflight_q;
  assign done_now    = (state_q == S_DRAIN) && (fifo_count_q == 2'd0) && !inflight_q;
  // A finishing frame releases the active slot in the same cycle a new switch arrives.
  assign active_free = (state_q == S_IDLE) || done_now;
  assign accept      = sw_valid && (active_free || !pend_valid_q);
  assign drop        = sw_valid && !accept;
  assign at_last     = (rd_addr_q == act_len_q - ONE);
  // Occupancy after this cycle's pop, so a held-high Out_Ready sustains one symbol per cycle.
  assign occ         = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue       = (state_q == S_READ) && (occ < 3'd2);

  always_comb begin
    state_d         = state_q;
    act_bank_d      = act_bank_q;
    act_len_d       = act_len_q;
    rd_addr_d       = rd_addr_q;
    pend_valid_d    = pend_valid_q;
    pend_bank_d     = pend_bank_q;
    pend_len_d      = pend_len_q;
    wr_bank_d       = wr_bank_q ^ accept;
    overflow_d      = overflow_q | drop;
    inflight_d      = issue;
    inflight_last_d = issue && at_last;
    fifo_count_d    = fifo_count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d        = wr_ptr_q ^ push;
    rd_ptr_d        = rd_ptr_q ^ pop;

    if (issue) begin
      if (at_last) state_d = S_DRAIN;
      else         rd_addr_d = rd_addr_q + ONE;
    end

    if (active_free) begin
      if (pend_valid_q) begin
        state_d      = S_READ;
        act_bank_d   = pend_bank_q;
        act_len_d    = pend_len_q;
        rd_addr_d    = '0;
        pend_valid_d = accept;
        if (accept) begin
          pend_bank_d = wr_bank_q;
          pend_len_d  = sw_len;
        end
      end else if (sw_valid) begin
        state_d    = S_READ;
        act_bank_d = wr_bank_q;
        act_len_d  = sw_len;
        rd_addr_d  = '0;
      end else begin
        state_d = S_IDLE;
      end
    end else if (accept) begin
      pend_valid_d = 1'b1;
      pend_bank_d  = wr_bank_q;
      pend_len_d   = sw_len;
    end
  end

  always_ff @(posedge CLK_PPR or negedge RST_PPR) begin
    if (!RST_PPR) begin
      state_q         <= S_IDLE;
      wr_bank_q       <= 1'b0;
      act_bank_q      <= 1'b0;
      act_len_q       <= '0;
      rd_addr_q       <= '0;
      pend_valid_q    <= 1'b0;
      pend_bank_q     <= 1'b0;
      pend_len_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_count_q    <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_bank_q       <= wr_bank_d;
      act_bank_q      <= act_bank_d;
      act_len_q       <= act_len_d;
      rd_addr_q       <= rd_addr_d;
      pend_valid_q    <= pend_valid_d;
      pend_bank_q     <= pend_bank_d;
      pend_len_q      <= pend_len_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_count_q    <= fifo_count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      overflow_q      <= overflow_d;
    end
  end

  always_ff @(posedge CLK_PPR or negedge RST_PPR) begin
    if (!RST_PPR) begin
      for (int i = 0; i < 2; i++) begin
        fifo_i_q[i]    <= '0;
        fifo_qd_q[i]   <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_i_q[wr_ptr_q]    <= Ram_I;
      fifo_qd_q[wr_ptr_q]   <= Ram_Q;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

`ifdef PPR_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, done_now};
    drop_cnt_d  = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK_PPR or negedge RST_PPR) begin
    if (!RST_PPR) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign Frame_Cnt = frame_cnt_q;
  assign Drop_Cnt  = drop_cnt_q;
`endif

  assign Wr_Bank     = wr_bank_q;
  assign Rd_Bank     = act_bank_q;
  assign Rd_addr     = rd_addr_q;
  assign read_enable = issue;
  assign Out_Valid   = out_valid;
  assign Out_I       = fifo_i_q[rd_ptr_q];
  assign Out_Q       = fifo_qd_q[rd_ptr_q];
  assign Out_Last    = out_valid && fifo_last_q[rd_ptr_q];
  assign Rd_Done     = done_now;
  assign Overflow    = overflow_q;

endmodule
